// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - funct codes of the eight HI/LO instructions
//   - 2-bit FSM state encodings
//   - small decode helpers used by the sequencer
package muldiv_seq_pkg;

   // funct field codes (R-type, opcode 000000)
   localparam logic [5:0] func_mfhi  = 6'b010000;
   localparam logic [5:0] func_mthi  = 6'b010001;
   localparam logic [5:0] func_mflo  = 6'b010010;
   localparam logic [5:0] func_mtlo  = 6'b010011;
   localparam logic [5:0] func_mult  = 6'b011000;
   localparam logic [5:0] func_multu = 6'b011001;
   localparam logic [5:0] func_div   = 6'b011010;
   localparam logic [5:0] func_divu  = 6'b011011;

   // FSM state encodings
   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_calc = 2'd1;
   localparam logic [1:0] st_fix  = 2'd2;

   // mult/multu/div/divu: the iterative operations
   function automatic logic is_iter_op(input logic [5:0] f);
      return (f == func_mult) || (f == func_multu) || (f == func_div) || (f == func_divu);
   endfunction

   // mfhi/mthi/mflo/mtlo: the register moves
   function automatic logic is_move_op(input logic [5:0] f);
      return (f == func_mfhi) || (f == func_mthi) || (f == func_mflo) || (f == func_mtlo);
   endfunction

   function automatic logic is_div_op(input logic [5:0] f);
      return (f == func_div) || (f == func_divu);
   endfunction

   function automatic logic is_signed_op(input logic [5:0] f);
      return (f == func_mult) || (f == func_div);
   endfunction

endpackage

// File: rtl/muldiv_dp.sv
// muldiv_dp: iterative multiply/divide datapath, one bit per step.
//   clk, rst_n     clock, asynchronous active-low reset
//   load           latch operand magnitudes, signs and op type
//   step           one shift-add (multiply) or restoring-subtract (divide) iteration
//   fix            commit the sign-corrected result into the accumulator
//   is_div         op type, sampled on load
//   is_signed      signedness, sampled on load
//   a, b           rs / rt operands, sampled on load
//   res_hi, res_lo sign-corrected result (HI/LO view), valid during the fix cycle
module muldiv_dp #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            fix,
   input  logic            is_div,
   input  logic            is_signed,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   // acc: multiply {partial product, multiplier}; divide {remainder, quotient/dividend}
   logic [2*XLEN-1:0] acc_q, acc_d;
   // opnd: multiplicand or divisor magnitude
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              div_q, div_d;
   logic              neg_res_q, neg_res_d;  // negate product / quotient
   logic              neg_rem_q, neg_rem_d;  // negate remainder (dividend negative)
   logic              div0_q, div0_d;

   logic              sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_t, div_diff;
   logic [XLEN-1:0]   rem, quo;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

   assign sa    = is_signed & a[XLEN-1];
   assign sb    = is_signed & b[XLEN-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

   assign rem = acc_q[2*XLEN-1:XLEN];
   assign quo = acc_q[XLEN-1:0];

   assign mul_sum  = {1'b0, rem} + {1'b0, opnd_q};
   assign div_t    = {rem, quo[XLEN-1]};
   assign div_diff = div_t - {1'b0, opnd_q};

   // Divide by zero naturally leaves |A| in the remainder; only the quotient needs forcing.
   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quo_fix  = div0_q ? '1 : (neg_res_q ? -quo : quo);
   assign rem_fix  = neg_rem_q ? -rem : rem;

   assign res_hi = div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
   assign res_lo = div_q ? quo_fix : prod_fix[XLEN-1:0];

   always_comb begin
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      if (load) begin
         div_d     = is_div;
         neg_res_d = sa ^ sb;
         neg_rem_d = is_div & sa;
         div0_d    = is_div & (b == '0);
         if (is_div) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
         end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
         end
      end else if (step) begin
         if (div_q) begin
            // compare, not borrow bit: a zero divisor must always "fit"
            if (div_t >= {1'b0, opnd_q}) begin
               acc_d = {div_diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
            end else begin
               acc_d = {div_t[XLEN-1:0], quo[XLEN-2:0], 1'b0};
            end
         end else if (acc_q[0]) begin
            acc_d = {mul_sum, quo[XLEN-1:1]};
         end else begin
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
         end
      end else if (fix) begin
         acc_d     = {res_hi, res_lo};
         neg_res_d = 1'b0;
         neg_rem_d = 1'b0;
         div0_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         opnd_q    <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: HI/LO owner and multi-cycle mult/div sequencer beside the ALU.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       R-type instruction in decode this cycle
//   Func        funct field
//   A, B        rs / rt values
//   HI, LO      HI/LO registers (mfhi/mflo read these directly)
//   busy        iterative operation in progress (CALC or FIX)
//   done        one-cycle pulse after HI/LO are written by mult/div
//   stall       HI/LO instruction presented while busy; the core holds the PC
module muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [5:0]      Func,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO,
   output logic            busy,
   output logic            done,
   output logic            stall
);
   import muldiv_seq_pkg::*;

   localparam int unsigned CntW = $clog2(XLEN);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            done_q, done_d;

   logic            load, step, fix;
   logic            cnt_last;
   logic [XLEN-1:0] res_hi, res_lo;

   assign busy     = (state_q != st_idle);
   assign stall    = busy & start & (is_iter_op(Func) | is_move_op(Func));
   assign cnt_last = (cnt_q == CntW'(XLEN - 1));
   assign step     = (state_q == st_calc);
   assign fix      = (state_q == st_fix);

   assign HI   = hi_q;
   assign LO   = lo_q;
   assign done = done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      load    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         st_idle: begin
            if (start) begin
               if (is_iter_op(Func)) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  state_d = st_calc;
               end else if (Func == func_mthi) begin
                  hi_d = A;
               end else if (Func == func_mtlo) begin
                  lo_d = A;
               end
            end
         end
         st_calc: begin
            cnt_d = cnt_q + 1'b1;  // wraps back to 0 on the last step
            if (cnt_last) begin
               state_d = st_fix;
            end
         end
         st_fix: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = st_idle;
         end
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= st_idle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   muldiv_dp #(
      .XLEN(XLEN)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .fix      (fix),
      .is_div   (is_div_op(Func)),
      .is_signed(is_signed_op(Func)),
      .a        (A),
      .b        (B),
      .res_hi   (res_hi),
      .res_lo   (res_lo)
   );

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  func;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int tests;
   int fails;

   int          nb;
   logic        ds, dl;
   logic [31:0] hv, lv;

   muldiv_seq #(
      .XLEN(32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .Func (func),
      .A    (a),
      .B    (b),
      .HI   (hi),
      .LO   (lo),
      .busy (busy),
      .done (done),
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op at a negedge, run until busy drops, capture results.
   task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                         output int nbusy, output logic done_seen, output logic done_late,
                         output logic [31:0] hres, output logic [31:0] lres);
      start = 1'b1; func = f; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; func = 6'b0;
      nbusy = 0;
      while (busy && nbusy < 100) begin
         nbusy++;
         @(negedge clk);
      end
      done_seen = done; hres = hi; lres = lo;
      @(negedge clk);
      done_late = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; func = 6'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
      tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      run_op(6'b011000, 32'd7, 32'hFFFF_FFFD, nb, ds, dl, hv, lv);
      tests++; if (hv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hv); end
      tests++; if (lv !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo: got %h want ffffffeb", lv); end
      tests++; if (nb !== 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 33", nb); end
      tests++; if (ds !== 1'b1) begin fails++; $display("FAIL mult_done: got %b want 1", ds); end
      tests++; if (dl !== 1'b0) begin fails++; $display("FAIL mult_done_width: got %b want 0", dl); end
      run_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, ds, dl, hv, lv);
      tests++; if (hv !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", hv); end
      tests++; if (lv !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", lv); end
      run_op(6'b011000, 32'h8000_0000, 32'h8000_0000, nb, ds, dl, hv, lv);
      tests++; if (hv !== 32'h4000_0000) begin fails++; $display("FAIL mult_minmin_hi: got %h want 40000000", hv); end
      tests++; if (lv !== 32'h0) begin fails++; $display("FAIL mult_minmin_lo: got %h want 0", lv); end
   endtask

   task automatic test_div();
      run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", lv); end
      tests++; if (hv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", hv); end
      tests++; if (nb !== 33) begin fails++; $display("FAIL div_busy_cycles: got %0d want 33", nb); end
      run_op(6'b011011, 32'hFFFF_FFF9, 32'd2, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'h7FFF_FFFC) begin fails++; $display("FAIL divu_lo: got %h want 7ffffffc", lv); end
      tests++; if (hv !== 32'h1) begin fails++; $display("FAIL divu_hi: got %h want 1", hv); end
      run_op(6'b011010, 32'd7, 32'hFFFF_FFFE, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lv); end
      tests++; if (hv !== 32'h1) begin fails++; $display("FAIL div_negdivisor_hi: got %h want 1", hv); end
   endtask

   task automatic test_div_edge();
      run_op(6'b011011, 32'd100, 32'd0, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu0_lo: got %h want ffffffff", lv); end
      tests++; if (hv !== 32'd100) begin fails++; $display("FAIL divu0_hi: got %h want 00000064", hv); end
      run_op(6'b011011, 32'h8000_0001, 32'd0, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu0_big_lo: got %h want ffffffff", lv); end
      tests++; if (hv !== 32'h8000_0001) begin fails++; $display("FAIL divu0_big_hi: got %h want 80000001", hv); end
      run_op(6'b011010, 32'hFFFF_FFF9, 32'd0, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_neg_lo: got %h want ffffffff", lv); end
      tests++; if (hv !== 32'hFFFF_FFF9) begin fails++; $display("FAIL div0_neg_hi: got %h want fffffff9", hv); end
      run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", lv); end
      tests++; if (hv !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", hv); end
   endtask

   task automatic test_moves_and_stall();
      int i;
      start = 1'b1; func = 6'b010011; a = 32'hCAFE_F00D;  // mtlo
      @(negedge clk);
      start = 1'b0;
      tests++; if (lo !== 32'hCAFE_F00D) begin fails++; $display("FAIL mtlo: got %h want cafef00d", lo); end
      start = 1'b1; func = 6'b010001; a = 32'h1234_5678;  // mthi
      @(negedge clk);
      start = 1'b0;
      tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi: got %h want 12345678", hi); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done);
      end
      // mult 3*5, then hammer with mult/mflo (and one add) while busy
      start = 1'b1; func = 6'b011000; a = 32'd3; b = 32'd5;
      @(negedge clk);
      i = 0;
      while (busy && i < 100) begin
         start = 1'b1; a = 32'd9; b = 32'd9;
         func = (i == 5) ? 6'b100000 : ((i % 2 == 1) ? 6'b010010 : 6'b011000);
         #1;
         tests++;
         if (i == 5 && stall !== 1'b0) begin
            fails++; $display("FAIL stall_unrecognised: cycle %0d got %b want 0", i, stall);
         end else if (i != 5 && stall !== 1'b1) begin
            fails++; $display("FAIL stall_busy: cycle %0d got %b want 1", i, stall);
         end
         tests++; if (hi !== 32'h1234_5678) begin
            fails++; $display("FAIL hi_hold: cycle %0d got %h want 12345678", i, hi);
         end
         i++;
         @(negedge clk);
      end
      start = 1'b0; func = 6'b0;
      tests++; if (i !== 33) begin fails++; $display("FAIL stall_busy_cycles: got %0d want 33", i); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done: got %b want 1", done); end
      tests++; if (hi !== 32'h0 || lo !== 32'd15) begin
         fails++; $display("FAIL stall_result: got %h_%h want 00000000_0000000f", hi, lo);
      end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || lo !== 32'd15) begin
         fails++; $display("FAIL stalled_ignored: got busy=%b lo=%h want 0 0000000f", busy, lo);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1; func = 6'b011000; a = 32'd7; b = 32'hFFFF_FFFD;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      tests++; if (done !== 1'b1 || hi !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL b2b_first: got done=%b hi=%h want 1 ffffffff", done, hi);
      end
      start = 1'b1; func = 6'b011011; a = 32'd100; b = 32'd7;  // divu in the done cycle
      @(negedge clk);
      start = 1'b0;
      tests++; if (busy !== 1'b1 || done !== 1'b0) begin
         fails++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
      end
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      tests++; if (n !== 33) begin fails++; $display("FAIL b2b_busy_cycles: got %0d want 33", n); end
      tests++; if (lo !== 32'd14 || hi !== 32'd2) begin
         fails++; $display("FAIL b2b_divu: got %h_%h want 00000002_0000000e", hi, lo);
      end
   endtask

   task automatic test_reset_abort();
      int dcount;
      start = 1'b1; func = 6'b011000; a = 32'd7; b = 32'hFFFF_FFFD;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
      tests++; if (hi !== 32'h0 || lo !== 32'h0) begin
         fails++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo);
      end
      dcount = 0;
      repeat (2) begin @(negedge clk); if (done) dcount++; end
      rst_n = 1'b1;
      repeat (40) begin @(negedge clk); if (done || busy) dcount++; end
      tests++; if (dcount !== 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", dcount); end
      run_op(6'b011000, 32'd6, 32'd7, nb, ds, dl, hv, lv);
      tests++; if (lv !== 32'd42 || hv !== 32'h0) begin
         fails++; $display("FAIL abort_fresh_mult: got %h_%h want 00000000_0000002a", hv, lv);
      end
      tests++; if (nb !== 33 || ds !== 1'b1) begin
         fails++; $display("FAIL abort_fresh_timing: got busy=%0d done=%b want 33 1", nb, ds);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_mult();
      test_div();
      test_div_edge();
      test_moves_and_stall();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
